// File: rtl/fpu_sched.sv
// rtl/fpu_sched.sv - FPU issue scheduler with a reservation table merging all units onto one writeback port
//
// Purpose: accepts one FP/conversion op per cycle, drives the shared operand bus and
// per-unit issue strobes, and schedules every result onto a single registered, tagged
// writeback port. Fixed-latency results (add, mul, converters) are placed in a
// reservation table at issue; the iterative divider writes back in any free slot.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready is combinational on req_op)
//   req_op, req_tag, req_x1/x2    op code, destination tag, operands
//   op_x1, op_x2                  operand bus to all units (x2 sign flipped for FSUB)
//   add_go, mul_go, div_start     one-cycle issue strobes in the accept cycle
//   add_y, mul_y                  pipelined unit results
//   floor_y, itof_y, ftoi_y       combinational converter results of op_x1
//   div_done, div_y               divider completion pulse and result
//   wb_valid, wb_tag, wb_data     registered writeback
//   busy                          any op outstanding
module fpu_sched #(
  parameter int TAG_W   = 6,
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  output logic [31:0]      op_x1,
  output logic [31:0]      op_x2,
  output logic             add_go,
  output logic             mul_go,
  output logic             div_start,
  input  logic [31:0]      add_y,
  input  logic [31:0]      mul_y,
  input  logic [31:0]      floor_y,
  input  logic [31:0]      itof_y,
  input  logic [31:0]      ftoi_y,
  input  logic             div_done,
  input  logic [31:0]      div_y,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data,
  output logic             busy
);

  localparam int D = ((LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL) + 1;

  typedef enum logic [1:0] {CLS_ADD, CLS_MUL, CLS_CVT, CLS_DIV} cls_e;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_HOLD} div_state_e;

  // Reservation table: slot k valid means a writeback happens k cycles from now.
  logic [D:1]       s_valid;
  logic [TAG_W-1:0] s_tag [1:D];
  cls_e             s_cls [1:D];

  // Table as it looks with this cycle's accept inserted, before the shift.
  logic [D:1]       ins_valid;
  logic [TAG_W-1:0] ins_tag [1:D];
  cls_e             ins_cls [1:D];

  div_state_e       div_state, div_state_nx;
  logic [TAG_W-1:0] div_tag;
  logic [31:0]      div_hold;
  logic [31:0]      cvt_hold, cvt_hold_nx, cvt_val;

  cls_e             cls;
  int               lat;
  logic             slot_taken;
  logic             accept, fix_acc, cvt_acc;
  logic             div_wb, div_latch;
  logic [31:0]      div_wb_data, fix_data;

  // Op decode: class and fixed latency (converters and illegal op complete at the accept edge).
  always_comb begin
    cls     = CLS_CVT;
    lat     = 0;
    cvt_val = 32'd0;
    case (req_op)
      3'd0, 3'd1: begin cls = CLS_ADD; lat = LAT_ADD; end
      3'd2:       begin cls = CLS_MUL; lat = LAT_MUL; end
      3'd3:       cvt_val = floor_y;
      3'd4:       cvt_val = itof_y;
      3'd5:       cvt_val = ftoi_y;
      3'd6:       cls = CLS_DIV;
      default:    cvt_val = 32'd0;
    endcase
  end

  // The op's target slot must be free in the current table, before the shift.
  always_comb begin
    slot_taken = 1'b0;
    for (int k = 1; k <= D; k++) begin
      if (k == lat + 1) slot_taken = s_valid[k];
    end
  end

  assign req_ready = !rst && ((cls == CLS_DIV) ? (div_state == DIV_IDLE) : !slot_taken);
  assign accept    = req_valid && req_ready;
  assign fix_acc   = accept && (cls != CLS_DIV);
  assign cvt_acc   = accept && (cls == CLS_CVT);

  assign add_go    = accept && (cls == CLS_ADD);
  assign mul_go    = accept && (cls == CLS_MUL);
  assign div_start = accept && (cls == CLS_DIV);

  assign op_x1 = req_x1;
  assign op_x2 = {req_x2[31] ^ (req_op == 3'd1), req_x2[30:0]};

  always_comb begin
    for (int k = 1; k <= D; k++) begin
      ins_valid[k] = s_valid[k];
      ins_tag[k]   = s_tag[k];
      ins_cls[k]   = s_cls[k];
      if (fix_acc && (k == lat + 1)) begin
        ins_valid[k] = 1'b1;
        ins_tag[k]   = req_tag;
        ins_cls[k]   = cls;
      end
    end
  end

  // A CVT op in slot 1 was accepted this very cycle, so its data is the value
  // being captured into cvt_hold now.
  assign cvt_hold_nx = cvt_acc ? cvt_val : cvt_hold;

  always_comb begin
    fix_data = cvt_hold_nx;
    case (ins_cls[1])
      CLS_ADD: fix_data = add_y;
      CLS_MUL: fix_data = mul_y;
      default: fix_data = cvt_hold_nx;
    endcase
  end

  // Divider FSM: the divider only gets the port when no fixed-latency op needs it.
  always_comb begin
    div_state_nx = div_state;
    div_wb       = 1'b0;
    div_latch    = 1'b0;
    div_wb_data  = div_y;
    case (div_state)
      DIV_IDLE: if (div_start) div_state_nx = DIV_RUN;
      DIV_RUN: begin
        if (div_done) begin
          if (!ins_valid[1]) begin
            div_wb       = 1'b1;
            div_state_nx = DIV_IDLE;
          end else begin
            div_latch    = 1'b1;
            div_state_nx = DIV_HOLD;
          end
        end
      end
      DIV_HOLD: begin
        div_wb_data = div_hold;
        if (!ins_valid[1]) begin
          div_wb       = 1'b1;
          div_state_nx = DIV_IDLE;
        end
      end
      default: div_state_nx = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) div_state <= DIV_IDLE;
    else     div_state <= div_state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid  <= '0;
      for (int k = 1; k <= D; k++) begin
        s_tag[k] <= '0;
        s_cls[k] <= CLS_CVT;
      end
      cvt_hold <= 32'd0;
      div_hold <= 32'd0;
      div_tag  <= '0;
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_data  <= 32'd0;
    end else begin
      for (int k = 1; k < D; k++) begin
        s_valid[k] <= ins_valid[k+1];
        s_tag[k]   <= ins_tag[k+1];
        s_cls[k]   <= ins_cls[k+1];
      end
      s_valid[D] <= 1'b0;
      if (cvt_acc)   cvt_hold <= cvt_val;
      if (div_start) div_tag  <= req_tag;
      if (div_latch) div_hold <= div_y;
      wb_valid <= ins_valid[1] || div_wb;
      if (ins_valid[1]) begin
        wb_tag  <= ins_tag[1];
        wb_data <= fix_data;
      end else if (div_wb) begin
        wb_tag  <= div_tag;
        wb_data <= div_wb_data;
      end
    end
  end

  assign busy = (|s_valid) || (div_state != DIV_IDLE);

endmodule

// File: tb/tb_fpu_sched.sv
// tb/tb_fpu_sched.sv - scoreboard bench for fpu_sched with directed vectors
module tb_fpu_sched;
  localparam int TAG_W   = 6;
  localparam int LAT_ADD = 2;
  localparam int LAT_MUL = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready;
  logic [2:0]       req_op;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      req_x1, req_x2, op_x1, op_x2;
  logic             add_go, mul_go, div_start;
  logic [31:0]      add_y, mul_y, floor_y, itof_y, ftoi_y;
  logic             div_done;
  logic [31:0]      div_y;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_data;
  logic             busy;

  fpu_sched #(.TAG_W(TAG_W), .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tag(req_tag),
    .req_x1(req_x1), .req_x2(req_x2), .op_x1(op_x1), .op_x2(op_x2),
    .add_go(add_go), .mul_go(mul_go), .div_start(div_start),
    .add_y(add_y), .mul_y(mul_y), .floor_y(floor_y), .itof_y(itof_y), .ftoi_y(ftoi_y),
    .div_done(div_done), .div_y(div_y),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int               cyc;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } exp_t;
  exp_t sb[$];

  // Reference floor for IEEE single: clear fraction bits, round negatives down.
  function automatic logic [31:0] floor_model(input logic [31:0] x);
    logic [7:0]  e;
    logic [31:0] ulp, t;
    e = x[30:23];
    if (x[30:0] == 31'd0) return x;
    if (e >= 8'd150) return x;
    if (e < 8'd127) return x[31] ? 32'hBF80_0000 : 32'h0000_0000;
    ulp = 32'd1 << (8'd150 - e);
    t = x & ~(ulp - 32'd1);
    if (x[31] && (t != x)) t = t + ulp;
    return t;
  endfunction

  // Stand-in unit models: integer arithmetic is enough to prove routing and timing.
  assign floor_y = floor_model(op_x1);
  assign itof_y  = {op_x1[15:0], op_x1[31:16]};
  assign ftoi_y  = ~op_x1;

  logic [31:0] add_pipe [LAT_ADD];
  logic [31:0] mul_pipe [LAT_MUL];
  always @(posedge clk) begin
    add_pipe[0] <= add_go ? (op_x1 + op_x2) : 32'hBAD0_0ADD;
    for (int i = 1; i < LAT_ADD; i++) add_pipe[i] <= add_pipe[i-1];
    mul_pipe[0] <= mul_go ? (op_x1 * op_x2) : 32'hBAD0_0111;
    for (int i = 1; i < LAT_MUL; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign add_y = add_pipe[LAT_ADD-1];
  assign mul_y = mul_pipe[LAT_MUL-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [TAG_W-1:0] tag,
                       input logic [31:0] x1, input logic [31:0] x2);
    req_valid = v; req_op = op; req_tag = tag; req_x1 = x1; req_x2 = x2;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, '0, 32'd0, 32'd0);
  endtask

  task automatic expect_wb(input int c, input logic [TAG_W-1:0] tag, input logic [31:0] d);
    sb.push_back('{c, tag, d});
  endtask

  // Monitor: every writeback must match an entry scheduled for this cycle; any
  // entry whose cycle has come without a writeback is reported missing.
  always @(negedge clk) begin : monitor
    int idx;
    int j;
    idx = -1;
    if (wb_valid === 1'b1) begin
      for (int i = 0; i < sb.size(); i++)
        if (idx < 0 && sb[i].cyc == cyc) idx = i;
      if (idx < 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got tag %h data %h expected no writeback (cycle %0d)",
                 wb_tag, wb_data, cyc);
      end else begin
        chk("wb_tag", 32'(wb_tag), 32'(sb[idx].tag));
        chk("wb_data", wb_data, sb[idx].data);
        sb.delete(idx);
      end
    end
    j = 0;
    while (j < sb.size()) begin
      if (sb[j].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL wb_missing: got no writeback expected tag %h data %h (cycle %0d)",
                 sb[j].tag, sb[j].data, sb[j].cyc);
        sb.delete(j);
      end else begin
        j++;
      end
    end
  end

  int t;

  initial begin
    rst = 1'b1; div_done = 1'b0; div_y = 32'd0;
    idle();

    // Reset
    tick(); mid();
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    tick(); mid();
    chk("rst_wb_tag", 32'(wb_tag), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_busy2", 32'(busy), 0);
    tick(); rst = 1'b0;
    for (int op = 0; op < 7; op++) begin
      req_op = 3'(op);
      #1;
      chk($sformatf("ready_op%0d", op), 32'(req_ready), 1);
    end
    chk("idle_add_go", 32'(add_go), 0);

    // Converters back to back, each writing back the next cycle
    tick(); t = cyc; drive(1'b1, 3'd3, 6'd5, 32'h3FC0_0000, 32'd0);
    expect_wb(t + 1, 6'd5, 32'h3F80_0000);
    mid(); chk("floor_ready", 32'(req_ready), 1);
    tick(); t = cyc; drive(1'b1, 3'd3, 6'd6, 32'hBFC0_0000, 32'd0);
    expect_wb(t + 1, 6'd6, 32'hC000_0000);
    tick(); t = cyc; drive(1'b1, 3'd4, 6'd7, 32'h1234_5678, 32'd0);
    expect_wb(t + 1, 6'd7, 32'h5678_1234);
    tick(); t = cyc; drive(1'b1, 3'd5, 6'd8, 32'h0F0F_0000, 32'd0);
    expect_wb(t + 1, 6'd8, 32'hF0F0_FFFF);
    tick(); t = cyc; drive(1'b1, 3'd7, 6'd9, 32'hFFFF_FFFF, 32'd0);
    expect_wb(t + 1, 6'd9, 32'h0000_0000);
    mid(); chk("illegal_ready", 32'(req_ready), 1);
    tick(); idle(); tick(); tick();

    // FADD then FLOOR colliding on slot 1
    tick(); t = cyc; drive(1'b1, 3'd0, 6'd1, 32'h1, 32'h2);
    expect_wb(t + 3, 6'd1, 32'h3);
    mid(); chk("fadd_ready", 32'(req_ready), 1); chk("fadd_go", 32'(add_go), 1);
    chk("fadd_op_x2", op_x2, 32'h2);
    tick(); idle();
    tick(); drive(1'b1, 3'd3, 6'd2, 32'h4020_0000, 32'd0);
    mid(); chk("conflict_ready", 32'(req_ready), 0);
    tick(); expect_wb(cyc + 1, 6'd2, 32'h4000_0000);
    mid(); chk("conflict_ready_next", 32'(req_ready), 1);
    tick(); idle(); tick(); tick();

    // FSUB sign flip, FADD pass-through, FMUL, one accept per cycle
    tick(); t = cyc; drive(1'b1, 3'd1, 6'd3, 32'h10, 32'h4000_0000);
    expect_wb(t + 3, 6'd3, 32'hC000_0010);
    mid(); chk("fsub_ready", 32'(req_ready), 1); chk("fsub_add_go", 32'(add_go), 1);
    chk("fsub_mul_go", 32'(mul_go), 0); chk("fsub_op_x2", op_x2, 32'hC000_0000);
    chk("fsub_op_x1", op_x1, 32'h10);
    tick(); drive(1'b1, 3'd0, 6'd4, 32'h10, 32'h4000_0000);
    expect_wb(t + 4, 6'd4, 32'h4000_0010);
    mid(); chk("fadd2_ready", 32'(req_ready), 1); chk("fadd_op_x2_keep", op_x2, 32'h4000_0000);
    tick(); drive(1'b1, 3'd2, 6'd8, 32'd3, 32'd5);
    expect_wb(t + 5, 6'd8, 32'd15);
    mid(); chk("fmul_ready", 32'(req_ready), 1); chk("fmul_go", 32'(mul_go), 1);
    tick(); idle(); tick(); tick(); tick();

    // FDIV with second FDIV blocked; div_done collides with FMUL slot 1
    tick(); t = cyc; drive(1'b1, 3'd6, 6'd9, 32'h1, 32'h2);
    mid(); chk("div1_ready", 32'(req_ready), 1); chk("div1_start", 32'(div_start), 1);
    tick(); drive(1'b1, 3'd2, 6'd11, 32'd7, 32'd6);
    expect_wb(t + 4, 6'd11, 32'd42);
    mid(); chk("div_mul_ready", 32'(req_ready), 1); chk("div_mul_start", 32'(div_start), 0);
    chk("div_busy", 32'(busy), 1);
    tick(); drive(1'b1, 3'd6, 6'd10, 32'h3, 32'h4);
    mid(); chk("div2_ready_run", 32'(req_ready), 0); chk("div2_start_run", 32'(div_start), 0);
    tick(); div_done = 1'b1; div_y = 32'hDEAD_BEEF;
    expect_wb(t + 5, 6'd9, 32'hDEAD_BEEF);
    mid(); chk("div2_ready_done", 32'(req_ready), 0);
    tick(); div_done = 1'b0; div_y = 32'd0;
    mid(); chk("div2_ready_hold", 32'(req_ready), 0);
    tick();
    mid(); chk("div2_ready_free", 32'(req_ready), 1); chk("div2_start", 32'(div_start), 1);
    tick(); idle();
    tick(); div_done = 1'b1; div_y = 32'h1234_0000;
    expect_wb(cyc + 1, 6'd10, 32'h1234_0000);
    tick(); div_done = 1'b0; div_y = 32'd0;
    mid(); chk("div_idle_busy", 32'(busy), 0);
    tick(); div_done = 1'b1; div_y = 32'hFFFF_0000;
    tick(); div_done = 1'b0; div_y = 32'd0;
    tick(); mid(); chk("div_stray_busy", 32'(busy), 0);

    // Reset discards an in-flight FMUL
    tick(); drive(1'b1, 3'd2, 6'd12, 32'd2, 32'd2);
    mid(); chk("rstmul_ready", 32'(req_ready), 1);
    tick(); idle(); rst = 1'b1;
    mid(); chk("rstmul_ready_in_rst", 32'(req_ready), 0); chk("rstmul_busy_before", 32'(busy), 1);
    tick(); rst = 1'b0;
    mid(); chk("rstmul_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      tick(); mid(); chk($sformatf("rstmul_wb_valid_%0d", i), 32'(wb_valid), 0);
    end

    // Reset discards a running FDIV; a later div_done is ignored
    tick(); drive(1'b1, 3'd6, 6'd13, 32'h5, 32'h6);
    mid(); chk("rstdiv_start", 32'(div_start), 1);
    tick(); idle(); rst = 1'b1;
    tick(); rst = 1'b0; req_op = 3'd6;
    mid(); chk("rstdiv_busy", 32'(busy), 0); chk("rstdiv_ready", 32'(req_ready), 1);
    tick(); idle(); div_done = 1'b1; div_y = 32'hCAFE_F00D;
    tick(); div_done = 1'b0; div_y = 32'd0;
    tick(); tick(); mid(); chk("rstdiv_busy_after", 32'(busy), 0);

    tick(); tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
